// File: rtl/sdio_pkg.sv
// Shared register map, control/status bit positions and SPI FSM state encoding
// for the SDIO SPI byte engine.
package sdio_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int unsigned CTRL_CS_EN   = 0;
    localparam int unsigned CTRL_FAST    = 1;
    localparam int unsigned CTRL_BUSY    = 4;
    localparam int unsigned CTRL_OVR     = 5;
    localparam int unsigned CTRL_CARD    = 6;
    localparam int unsigned CTRL_OVR_CLR = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/sdio_spi_master_if.sv
// Register strobe bus between the SDIO address decoder (master) and the SPI engine (slave).
interface sdio_spi_master_if;

    logic       reg_sel;
    logic [1:0] reg_addr;
    logic       reg_rw_n;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_ack;

    modport master (
        output reg_sel, reg_addr, reg_rw_n, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_sel, reg_addr, reg_rw_n, reg_wdata,
        output reg_rdata, reg_ack
    );

endinterface

// File: rtl/sdio_spi_master_shifter.sv
// SPI mode-0 byte shifter: half-period divider, MSB-first transmit, MISO capture on SCLK rise.
module spi_byte_shifter
    import sdio_pkg::*;
#(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned SLOW_DIV = 62
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fast,
    input  logic [DIV_W-1:0] div_fast,
    input  logic [7:0]       tx,
    output logic [7:0]       rx,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
    logic             busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic             tick_c;

    assign tick_c = (cnt_q == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            sh_q    <= '0;
            rx_q    <= 8'hFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)  state_d = LOW;
            LOW:     if (tick_c) state_d = HIGH;
            HIGH:    if (tick_c) state_d = (bit_q == 3'd7) ? IDLE : LOW;
            default: state_d = IDLE;
        endcase
    end

    // Datapath follows the current state; the divider rate is frozen at byte start.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        tx_d   = tx_q;
        sh_d   = sh_q;
        rx_d   = rx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d   = tx;
                    bit_d  = 3'd0;
                    mosi_d = tx[7];
                    sclk_d = 1'b0;
                    div_d  = fast ? div_fast : DIV_W'(SLOW_DIV);
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            LOW: begin
                if (tick_c) begin
                    sclk_d = 1'b1;
                    sh_d   = {sh_q[6:0], miso};
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (tick_c) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bit_q == 3'd7) begin
                        rx_d   = sh_q;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        mosi_d = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = tx_q[6];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign rx   = rx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/sdio_spi_master.sv
// SDIO SPI master: register decode, overrun flag, card-detect synchroniser and bus acknowledge
// around the SPI byte shifter.
module sdio_spi_master
    import sdio_pkg::*;
#(
    parameter int unsigned SLOW_DIV = 62,
    parameter int unsigned FAST_DIV = 0,
    parameter int unsigned DIV_W    = 8
) (
    input  logic              C50M,
    input  logic              RESET,
    sdio_spi_master_if.slave  bus,
    output logic              DONE,
    output logic              SD_SCLK,
    output logic              SD_MOSI,
    input  logic              SD_MISO,
    output logic              SD_CS_n,
    input  logic              SD_CD_n
);

    logic             ack_q, ack_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             cs_n_q, cs_n_d, fast_q, fast_d, ovr_q, ovr_d;
    logic [DIV_W-1:0] div_fast_q, div_fast_d;
    logic             cd_meta_q, cd_sync_q;
    logic             wr_c, rd_c, start_c, busy;
    logic [7:0]       rx, stat_c;

    assign wr_c    = bus.reg_sel && !bus.reg_rw_n;
    assign rd_c    = bus.reg_sel &&  bus.reg_rw_n;
    assign start_c = wr_c && (bus.reg_addr == REG_DATA) && !busy;

    always_ff @(posedge C50M) begin
        if (RESET) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            cs_n_q     <= 1'b1;
            fast_q     <= 1'b0;
            ovr_q      <= 1'b0;
            div_fast_q <= DIV_W'(FAST_DIV);
            cd_meta_q  <= 1'b1;
            cd_sync_q  <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            cs_n_q     <= cs_n_d;
            fast_q     <= fast_d;
            ovr_q      <= ovr_d;
            div_fast_q <= div_fast_d;
            cd_meta_q  <= SD_CD_n;
            cd_sync_q  <= cd_meta_q;
        end
    end

    // Register writes and read-data mux; read data is only meaningful alongside the ack.
    always_comb begin
        ack_d      = bus.reg_sel;
        rdata_d    = '0;
        cs_n_d     = cs_n_q;
        fast_d     = fast_q;
        ovr_d      = ovr_q;
        div_fast_d = div_fast_q;

        stat_c               = '0;
        stat_c[CTRL_CS_EN]   = !cs_n_q;
        stat_c[CTRL_FAST]    = fast_q;
        stat_c[CTRL_BUSY]    = busy;
        stat_c[CTRL_OVR]     = ovr_q;
        stat_c[CTRL_CARD]    = !cd_sync_q;

        if (wr_c) begin
            unique case (bus.reg_addr)
                REG_DATA: if (busy) ovr_d = 1'b1;
                REG_CTRL: begin
                    cs_n_d = !bus.reg_wdata[CTRL_CS_EN];
                    fast_d = bus.reg_wdata[CTRL_FAST];
                    if (bus.reg_wdata[CTRL_OVR_CLR]) ovr_d = 1'b0;
                end
                REG_DIV:  div_fast_d = DIV_W'(bus.reg_wdata);
                default:  ;
            endcase
        end

        if (rd_c) begin
            unique case (bus.reg_addr)
                REG_DATA: rdata_d = rx;
                REG_CTRL: rdata_d = stat_c;
                REG_DIV:  rdata_d = 8'(div_fast_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    spi_byte_shifter #(
        .DIV_W    (DIV_W),
        .SLOW_DIV (SLOW_DIV)
    ) u_shifter (
        .clk      (C50M),
        .rst      (RESET),
        .start    (start_c),
        .fast     (fast_q),
        .div_fast (div_fast_q),
        .tx       (bus.reg_wdata),
        .rx       (rx),
        .busy     (busy),
        .done     (DONE),
        .sclk     (SD_SCLK),
        .mosi     (SD_MOSI),
        .miso     (SD_MISO)
    );

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign SD_CS_n       = cs_n_q;

endmodule

// File: doc/sdio_spi_master.md
Name: sdio_spi_master

Overview:
- SPI byte engine behind the SDIO card's Zorro II window; the SD card is the slave.
- The SDIO address decoder drives register strobes into this block, and the block returns read data and an acknowledge that feeds the CPU DTACK path.
- Each byte transfer runs in SPI mode 0, at a slow identification rate or a fast data rate.
- Exposes data, control/status and divider registers.

Parameters:
- SLOW_DIV, 62, SCLK half-period minus one in C50M cycles for slow mode (50 MHz/126 ≈ 397 kHz, within the 400 kHz SD init limit).
- FAST_DIV, 0, half-period minus one for fast mode at reset (25 MHz).
- DIV_W, 8, width of the divider counter and the DIV register.

Ports:
- C50M  in  1  sole clock. One clock; reset is synchronous and active-high.
- RESET  in  1  synchronous active-high reset.
- REG_SEL  in  1  one-cycle access strobe from the SDIO decoder.
- REG_ADDR  in  2  register select: 0 DATA, 1 CTRL/STAT, 2 DIV, 3 reserved.
- REG_RW_n  in  1  1 = read, 0 = write.
- REG_WDATA  in  8  write data (D15:8 of the bus).
- REG_RDATA  out  8  read data, valid while REG_ACK = 1.
- REG_ACK  out  1  one-cycle acknowledge.
- DONE  out  1  one-cycle pulse at end of each byte.
- SD_SCLK  out  1  SPI clock, idle low.
- SD_MOSI  out  1  SPI data out.
- SD_MISO  in  1  SPI data in.
- SD_CS_n  out  1  chip select.
- SD_CD_n  in  1  card detect (asynchronous).

Behaviour:
Reset values:
- REG_ACK=0, REG_RDATA=0, DONE=0, SD_SCLK=0, SD_MOSI=1, SD_CS_n=1.
- busy=0, fast=0, cs_en=0, ovr=0, rx=0xFF.
- div_fast=FAST_DIV.

Reset mid-transfer aborts immediately:
- Outputs return to their reset values on the next edge.
- No DONE pulse is generated.

Register access:
- REG_ACK is asserted exactly 1 cycle after REG_SEL, for every address including 3.
- REG_RDATA is registered in the same cycle as the acknowledge.
- Read DATA returns rx, the last completed byte, even while busy (stale value).
- Write DATA while idle starts a transfer; busy=1 in the cycle after REG_SEL.
- Write DATA while busy is ignored and sets ovr.
- CTRL write bits:
  - bit0 cs_en; SD_CS_n = !cs_en, updated one cycle after the write, even while busy.
  - bit1 fast.
  - bit7 writes 1 to clear ovr.
- CTRL read bits: bit0 cs_en, bit1 fast, bit4 busy, bit5 ovr, bit6 card-present = !cd_sync, other bits 0.
- fast is sampled only at transfer start; a change mid-byte has no effect until the next byte.
- DIV write sets div_fast; a read returns it. SLOW_DIV is fixed.
- Address 3: reads 0x00, writes are ignored.

FSM states IDLE, LOW, HIGH:
- IDLE→LOW on accepted DATA write:
  - load tx=REG_WDATA, bit_cnt=0, SD_MOSI=tx[7], SD_SCLK=0.
  - latch div = fast ? div_fast : SLOW_DIV, cnt=0.
- LOW: when cnt==div, SD_SCLK=1, sample SD_MISO into shift LSB, cnt=0, go to HIGH; otherwise cnt++.
- HIGH: when cnt==div:
  - SD_SCLK=0.
  - if bit_cnt==7: rx=shift, busy=0, DONE=1 for one cycle, SD_MOSI=1, go to IDLE.
  - otherwise: bit_cnt++, SD_MOSI=next tx bit (MSB first), cnt=0, go to LOW.
- Byte latency from accept to busy=0 is exactly 16*(div+1) cycles. SCLK duty is 50%.

Other rules:
- A DATA write in the same cycle busy clears, or in the same cycle as DONE, is accepted (back-to-back). The FSM is in IDLE in that cycle.
- SD_MISO is sampled unsynchronised; the board guarantees setup at 25 MHz.
- SD_CD_n passes through a 2-flop synchroniser; card-present appears 2 cycles later.
- The block never gates SD_CS_n on busy; software owns framing.

Decomposition:
- Shared package sdio_pkg holds:
  - REG_DATA=2'd0, REG_CTRL=2'd1, REG_DIV=2'd2.
  - CTRL bit-index constants.
  - FSM state enum (IDLE, LOW, HIGH).
- One sub-module, spi_byte_shifter, holds the FSM, divider counter and shift registers, with a start/tx/rx/busy/done interface.
- The top holds register decode, ovr, the synchroniser and the acknowledge.

Test Plan:
- Reset, then read CTRL → REG_ACK one cycle after REG_SEL; RDATA=0x40 when SD_CD_n=0 (card present), 0x00 when SD_CD_n=1. SD_CS_n=1, SD_SCLK=0, SD_MOSI=1.
- CTRL=0x01, then slow-mode write DATA=0xA5 with a MISO model returning 0x3C → SD_CS_n=0 one cycle after the CTRL write; 8 SCLK rising edges with MOSI 1,0,1,0,0,1,0,1; busy high for 16*63=1008 cycles; DONE pulse; DATA read=0x3C.
- CTRL=0x03, DIV=0, write 0xFF → SCLK period 2 cycles; busy for 16 cycles; a second write in the DONE cycle is accepted with no gap.
- Write DATA while busy → ignored, the MOSI pattern is unchanged, STAT bit5=1; CTRL write 0x83 (keeps cs_en and fast) → bit5=0.
- Assert RESET at bit 3 of a transfer → the next cycle shows SCLK=0, CS_n=1, busy=0, no DONE; a subsequent transfer is correct.
- Toggle fast mid-byte → the current byte keeps its rate; the next byte uses the new rate.
